// File: rtl/bary_pkg.sv
// -----------------------------------------------------------------------------
// bary_pkg
// Shared types, widths and the round/saturate helper for the barycentric
// attribute interpolator.
//   VAL_W / COEF_W / COEF_F / TAG_W : default widths used by the datapath
//   PROD_W : lossless width of one weight*attribute product
//   SUM_W  : width of the three-product sum (two guard bits)
//   stage_ctl_t : per-stage control/sideband (valid, in_tri, tag)
//   sat_round() : round-half-up, arithmetic shift, clamp to a signed range
// -----------------------------------------------------------------------------
package bary_pkg;

  localparam int VAL_W  = 16;
  localparam int COEF_W = 18;
  localparam int COEF_F = 14;
  localparam int TAG_W  = 20;
  localparam int PROD_W = VAL_W + COEF_W;
  localparam int SUM_W  = PROD_W + 2;

  typedef struct packed {
    logic             valid;
    logic             in_tri;
    logic [TAG_W-1:0] tag;
  } stage_ctl_t;

  typedef struct packed {
    logic                    sat;
    logic signed [VAL_W-1:0] val;
  } sat_res_t;

  // Round half up by adding 2^(frac-1) before the arithmetic shift, then clamp
  // to the signed 'width'-bit range. One extra bit keeps the rounding add exact.
  function automatic sat_res_t sat_round(input logic signed [SUM_W-1:0] sum,
                                         input int frac,
                                         input int width);
    logic signed [SUM_W:0] one_v;
    logic signed [SUM_W:0] rnd_v;
    logic signed [SUM_W:0] max_v;
    logic signed [SUM_W:0] min_v;
    sat_res_t              res;
    one_v = {{SUM_W{1'b0}}, 1'b1};
    rnd_v = $signed({sum[SUM_W-1], sum}) + (one_v <<< (frac - 1));
    rnd_v = rnd_v >>> frac;
    max_v = (one_v <<< (width - 1)) - one_v;
    min_v = -(one_v <<< (width - 1));
    if (rnd_v > max_v) begin
      res.sat = 1'b1;
      res.val = max_v[VAL_W-1:0];
    end else if (rnd_v < min_v) begin
      res.sat = 1'b1;
      res.val = min_v[VAL_W-1:0];
    end else begin
      res.sat = 1'b0;
      res.val = rnd_v[VAL_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/bary_interp_lane.sv
// -----------------------------------------------------------------------------
// bary_interp_lane
// One attribute channel: three signed multiplies (S1), three-way add (S2),
// round/shift/saturate into the output register (S3).
//   i_clk, i_rst_n : clock, async active-low reset (output regs only)
//   i_ld1..i_ld3   : per-stage load enables from the top-level valid chain
//   i_coef         : weights w0..w2, COEF_WIDTH each, w0 in the low bits
//   i_vals         : attributes a0..a2 of this channel, VAL_WIDTH each
//   o_val, o_sat   : registered interpolated value and saturation flag
// -----------------------------------------------------------------------------
module bary_interp_lane
  import bary_pkg::*;
#(
  parameter int VAL_WIDTH  = VAL_W,
  parameter int COEF_WIDTH = COEF_W,
  parameter int SHIFT      = COEF_F
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ld1,
  input  logic                    i_ld2,
  input  logic                    i_ld3,
  input  logic [3*COEF_WIDTH-1:0] i_coef,
  input  logic [3*VAL_WIDTH-1:0]  i_vals,
  output logic [VAL_WIDTH-1:0]    o_val,
  output logic                    o_sat
);

  localparam int LP_W = VAL_WIDTH + COEF_WIDTH;
  localparam int LS_W = LP_W + 2;

  logic signed [LP_W-1:0] r_p [3];
  logic signed [LS_W-1:0] r_sum;
  sat_res_t               w_res;

  // S1: full-precision products, operands sign-extended to the product width
  always_ff @(posedge i_clk) begin
    if (i_ld1) begin
      for (int k = 0; k < 3; k++) begin
        r_p[k] <= LP_W'($signed(i_coef[k*COEF_WIDTH +: COEF_WIDTH]))
                * LP_W'($signed(i_vals[k*VAL_WIDTH +: VAL_WIDTH]));
      end
    end
  end

  // S2: sum of the three products with two guard bits
  always_ff @(posedge i_clk) begin
    if (i_ld2) begin
      r_sum <= LS_W'(r_p[0]) + LS_W'(r_p[1]) + LS_W'(r_p[2]);
    end
  end

  // Round/saturate of the S2 sum feeding the output register
  always_comb begin
    w_res = sat_round(SUM_W'(r_sum), SHIFT, VAL_WIDTH);
  end

  // S3: output register, cleared by reset so idle outputs read as zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_val <= '0;
      o_sat <= 1'b0;
    end else if (i_ld3) begin
      o_val <= w_res.val;
      o_sat <= w_res.sat;
    end
  end

endmodule

// File: rtl/barycentric_attr_interp.sv
// -----------------------------------------------------------------------------
// barycentric_attr_interp
// NCH-channel barycentric interpolator: out[c] = sat(round(w0*a0+w1*a1+w2*a2)).
// Three-stage pipeline with a valid/ready handshake and per-stage,
// bubble-collapsing stalls. Sideband (in_tri, tag) rides with each beat.
//   clk_in, rst_n_in          : clock, async active-low reset
//   valid_in / ready_out      : upstream handshake
//   in_tri_in, coef_in, vals_in, tag_in : beat payload (vals channel-major)
//   valid_out / ready_in      : downstream handshake
//   vals_out, sat_out, in_tri_out, tag_out : registered result beat
// -----------------------------------------------------------------------------
module barycentric_attr_interp
  import bary_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int VAL_WIDTH    = VAL_W,
  parameter int VAL_FRAC     = 14,
  parameter int COEF_WIDTH   = COEF_W,
  parameter int COEF_FRAC    = COEF_F,
  parameter int TAG_WIDTH    = TAG_W,
  parameter int DROP_OUTSIDE = 1
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic                        in_tri_in,
  input  logic [3*COEF_WIDTH-1:0]     coef_in,
  input  logic [NCH*3*VAL_WIDTH-1:0]  vals_in,
  input  logic [TAG_WIDTH-1:0]        tag_in,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [NCH*VAL_WIDTH-1:0]    vals_out,
  output logic [NCH-1:0]              sat_out,
  output logic                        in_tri_out,
  output logic [TAG_WIDTH-1:0]        tag_out
);

  // Products carry VAL_FRAC+COEF_FRAC fraction bits; shift back to VAL_FRAC.
  localparam int SHIFT = (VAL_FRAC + COEF_FRAC) - VAL_FRAC;

  stage_ctl_t r_s1, r_s2, r_s3;
  logic       w_en1, w_en2, w_en3;
  logic       w_keep;
  logic       w_ld1, w_ld2, w_ld3;

  // Stall chain: a stage may load when empty or when its contents move on.
  // Outside-triangle beats are swallowed at the input when dropping is enabled.
  always_comb begin
    w_en3 = !r_s3.valid || ready_in;
    w_en2 = !r_s2.valid || w_en3;
    w_en1 = !r_s1.valid || w_en2;
    if (DROP_OUTSIDE != 0) begin
      w_keep = valid_in && in_tri_in;
    end else begin
      w_keep = valid_in;
    end
    w_ld1 = w_en1 && w_keep;
    w_ld2 = w_en2 && r_s1.valid;
    w_ld3 = w_en3 && r_s2.valid;
  end

  assign ready_out  = w_en1;
  assign valid_out  = r_s3.valid;
  assign in_tri_out = r_s3.in_tri;
  assign tag_out    = r_s3.tag;

  // Valid bits and sideband through S1..S3; payload only moves with a real beat
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      if (w_en1) begin
        r_s1.valid <= w_keep;
        if (w_keep) begin
          r_s1.in_tri <= in_tri_in;
          r_s1.tag    <= tag_in;
        end
      end
      if (w_en2) begin
        r_s2.valid <= r_s1.valid;
        if (r_s1.valid) begin
          r_s2.in_tri <= r_s1.in_tri;
          r_s2.tag    <= r_s1.tag;
        end
      end
      if (w_en3) begin
        r_s3.valid <= r_s2.valid;
        if (r_s2.valid) begin
          r_s3.in_tri <= r_s2.in_tri;
          r_s3.tag    <= r_s2.tag;
        end
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    bary_interp_lane #(
      .VAL_WIDTH (VAL_WIDTH),
      .COEF_WIDTH(COEF_WIDTH),
      .SHIFT     (SHIFT)
    ) u_lane (
      .i_clk  (clk_in),
      .i_rst_n(rst_n_in),
      .i_ld1  (w_ld1),
      .i_ld2  (w_ld2),
      .i_ld3  (w_ld3),
      .i_coef (coef_in),
      .i_vals (vals_in[c*3*VAL_WIDTH +: 3*VAL_WIDTH]),
      .o_val  (vals_out[c*VAL_WIDTH +: VAL_WIDTH]),
      .o_sat  (sat_out[c])
    );
  end

endmodule

// File: tb/tb_barycentric_attr_interp.sv
// -----------------------------------------------------------------------------
// tb_barycentric_attr_interp
// Table-driven vectors plus hand-written sequences (latency, backpressure,
// drop, mid-stream reset) with a queue scoreboard checked at the negedge.
// -----------------------------------------------------------------------------
module tb_barycentric_attr_interp;

  typedef struct packed {
    logic [2:0][17:0]       cf;
    logic [3:0][2:0][15:0]  vv;
    logic                   in_tri;
    logic [19:0]            tag;
  } beat_t;

  typedef struct packed {
    logic [3:0][15:0] v;
    logic [3:0]       s;
    logic             in_tri;
    logic [19:0]      tag;
  } exp_t;

  typedef struct packed {
    beat_t            b;
    logic [3:0][15:0] ev;
    logic [3:0]       es;
  } vec_t;

  logic         clk_in, rst_n_in, valid_in, ready_out, in_tri_in;
  logic [53:0]  coef_in;
  logic [191:0] vals_in;
  logic [19:0]  tag_in, tag_out;
  logic         valid_out, ready_in, in_tri_out;
  logic [63:0]  vals_out;
  logic [3:0]   sat_out;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  logic rand_ready  = 1'b0;
  logic ready_force = 1'b1;

  barycentric_attr_interp dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(ready_out),
    .in_tri_in(in_tri_in), .coef_in(coef_in), .vals_in(vals_in), .tag_in(tag_in),
    .valid_out(valid_out), .ready_in(ready_in), .vals_out(vals_out), .sat_out(sat_out),
    .in_tri_out(in_tri_out), .tag_out(tag_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Downstream ready: forced value or random toggling
  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      if (rand_ready) ready_in = 1'($urandom_range(0, 1));
      else            ready_in = ready_force;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: exact integer sum, round half up, clamp to 16-bit signed
  function automatic exp_t model(input beat_t b);
    exp_t   e;
    longint s, r;
    e.in_tri = b.in_tri;
    e.tag    = b.tag;
    for (int c = 0; c < 4; c++) begin
      s = 0;
      for (int k = 0; k < 3; k++)
        s += longint'($signed(b.cf[k])) * longint'($signed(b.vv[c][k]));
      r = (s + 64'sd8192) >>> 14;
      if (r > 64'sd32767)       begin e.v[c] = 16'h7FFF; e.s[c] = 1'b1; end
      else if (r < -64'sd32768) begin e.v[c] = 16'h8000; e.s[c] = 1'b1; end
      else                      begin e.v[c] = 16'(r);   e.s[c] = 1'b0; end
    end
    return e;
  endfunction

  function automatic exp_t exp_of(input vec_t t);
    exp_t e;
    e.v = t.ev; e.s = t.es; e.in_tri = t.b.in_tri; e.tag = t.b.tag;
    return e;
  endfunction

  function automatic beat_t rand_beat(input logic tri_v, input logic [19:0] tag_v);
    beat_t b;
    int    t;
    b.in_tri = tri_v;
    b.tag    = tag_v;
    for (int k = 0; k < 3; k++) begin
      t = int'($urandom_range(0, 32768)) - 16384;
      b.cf[k] = 18'(t);
    end
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 3; k++) begin
        t = (int'($urandom_range(0, 65535)) - 32768) / (1 << (2 * c));
        b.vv[c][k] = 16'(t);
      end
    return b;
  endfunction

  // Present a beat until accepted; push its expectation on acceptance
  task automatic send(input beat_t b, input logic push_it, input exp_t e);
    @(posedge clk_in);
    #1;
    valid_in = 1'b1; coef_in = b.cf; vals_in = b.vv; in_tri_in = b.in_tri; tag_in = b.tag;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_in);
      if (ready_out) begin
        if (push_it) sbq.push_back(e);
        return;
      end
    end
    total++; bad++;
    $display("FAIL accept_timeout actual=no_accept required=accept tag=%0d", b.tag);
  endtask

  task automatic idle();
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sbq.size() != 0; n++) @(negedge clk_in);
    repeat (3) @(negedge clk_in);
    check("drain_left", 128'(sbq.size()), 128'd0);
  endtask

  // Scoreboard and hold-while-stalled monitor
  logic stall_r = 1'b0;
  exp_t held_r, cur_m, exp_m;
  always @(negedge clk_in) begin
    cur_m = {vals_out, sat_out, in_tri_out, tag_out};
    if (!rst_n_in) begin
      stall_r = 1'b0;
    end else begin
      if (stall_r) check("hold", {valid_out, cur_m}, {1'b1, held_r});
      if (valid_out && ready_in) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat actual=tag %0d required=no_output", tag_out);
        end else begin
          exp_m = sbq.pop_front();
          check("beat", cur_m, exp_m);
        end
      end
      stall_r = valid_out && !ready_in;
      held_r  = cur_m;
    end
  end

  vec_t  tbl[5];
  beat_t rb;

  initial begin
    valid_in = 1'b0; in_tri_in = 1'b0; coef_in = '0; vals_in = '0; tag_in = '0;
    rst_n_in = 1'b0;
    for (int i = 0; i < 5; i++) tbl[i] = '0;
    // identity: w=(1,0,0)
    tbl[0].b.cf[0] = 18'd16384;
    tbl[0].b.vv[0][0] = 16'd12345; tbl[0].b.vv[0][1] = 16'hFFFF; tbl[0].b.vv[0][2] = 16'hFFFF;
    tbl[0].ev[0] = 16'd12345; tbl[0].b.in_tri = 1'b1; tbl[0].b.tag = 20'd1;
    // mixed weights
    tbl[1].b.cf[0] = 18'd4096; tbl[1].b.cf[1] = 18'd4096; tbl[1].b.cf[2] = 18'd8192;
    tbl[1].b.vv[0][0] = 16'd16384; tbl[1].b.vv[0][2] = 16'hE000;
    for (int k = 0; k < 3; k++) tbl[1].b.vv[1][k] = 16'd8192;
    tbl[1].ev[1] = 16'd8192; tbl[1].b.in_tri = 1'b1; tbl[1].b.tag = 20'd2;
    // rounding, positive weight: 0.5 LSB -> 1, just under -> 0
    tbl[2].b.cf[0] = 18'd1;
    tbl[2].b.vv[0][0] = 16'd8192; tbl[2].b.vv[1][0] = 16'd8191;
    tbl[2].ev[0] = 16'd1; tbl[2].b.in_tri = 1'b1; tbl[2].b.tag = 20'd3;
    // rounding, negative weight: -0.5 -> 0, beyond -> -1, +0.5 via negative val -> 1
    tbl[3].b.cf[0] = 18'h3FFFF;
    tbl[3].b.vv[0][0] = 16'd8192; tbl[3].b.vv[1][0] = 16'd8193; tbl[3].b.vv[2][0] = 16'hE000;
    tbl[3].ev[1] = 16'hFFFF; tbl[3].ev[2] = 16'd1; tbl[3].b.in_tri = 1'b1; tbl[3].b.tag = 20'd4;
    // saturation both ways, plus exact max/min without saturation
    tbl[4].b.cf[0] = 18'd16384; tbl[4].b.cf[1] = 18'd16384;
    tbl[4].b.vv[0][0] = 16'd30000; tbl[4].b.vv[0][1] = 16'd30000;
    tbl[4].b.vv[1][0] = 16'h8AD0;  tbl[4].b.vv[1][1] = 16'h8AD0;
    tbl[4].b.vv[2][0] = 16'd16384; tbl[4].b.vv[2][1] = 16'd16383;
    tbl[4].b.vv[3][0] = 16'hC000;  tbl[4].b.vv[3][1] = 16'hC000;
    tbl[4].ev[0] = 16'h7FFF; tbl[4].ev[1] = 16'h8000; tbl[4].ev[2] = 16'h7FFF; tbl[4].ev[3] = 16'h8000;
    tbl[4].es = 4'b0011; tbl[4].b.in_tri = 1'b1; tbl[4].b.tag = 20'd5;

    // reset state
    repeat (3) @(negedge clk_in);
    check("rst_valid_out", 128'(valid_out), 128'd0);
    check("rst_fields", 128'({vals_out, sat_out, in_tri_out, tag_out}), 128'd0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("ready_after_rst", 128'(ready_out), 128'd1);

    // identity with latency: accept cycle 0, valid_out first seen in cycle 3
    send(tbl[0].b, 1'b1, exp_of(tbl[0]));
    idle();
    @(negedge clk_in); check("lat_c1", 128'(valid_out), 128'd0);
    @(negedge clk_in); check("lat_c2", 128'(valid_out), 128'd0);
    @(negedge clk_in); check("lat_c3", 128'(valid_out), 128'd1);
    drain();

    for (int i = 1; i < 5; i++) send(tbl[i].b, 1'b1, exp_of(tbl[i]));
    idle();
    drain();

    // backpressure and ordering
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rb = rand_beat(1'b1, 20'(i));
      send(rb, 1'b1, model(rb));
    end
    idle();
    drain();

    // outside-triangle beats are dropped; only even tags come out
    for (int i = 0; i < 10; i++) begin
      rb = rand_beat(1'((i % 2) == 0), 20'(100 + i));
      send(rb, rb.in_tri, model(rb));
    end
    idle();
    drain();
    rand_ready = 1'b0;

    // fill the pipe under backpressure, then reset mid-stream
    ready_force = 1'b0;
    repeat (2) @(posedge clk_in);
    for (int i = 0; i < 3; i++) begin
      rb = rand_beat(1'b1, 20'(200 + i));
      send(rb, 1'b1, model(rb));
    end
    idle();
    @(negedge clk_in);
    check("full_valid_out", 128'(valid_out), 128'd1);
    check("full_ready_out", 128'(ready_out), 128'd0);
    #2 rst_n_in = 1'b0;
    #1;
    check("midrst_valid_out", 128'(valid_out), 128'd0);
    check("midrst_fields", 128'({vals_out, sat_out, in_tri_out, tag_out}), 128'd0);
    sbq.delete();
    ready_force = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (10) @(negedge clk_in);
    check("no_stale", 128'(valid_out), 128'd0);

    // recovery after reset
    send(tbl[4].b, 1'b1, exp_of(tbl[4]));
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
